phase_measure_sequencer: RTL and testbench



---
 rtl/phase_measure_sequencer_if.sv | 49 ++++
 rtl/phase_measure_sequencer.sv | 169 ++++++++++++++++
 tb/tb_phase_measure_sequencer.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/phase_measure_sequencer_if.sv
// Handshake bundle shared by the phase-measure sequencer, the measurement
// block (request/response) and the dprintf request path.
interface phase_measure_sequencer_if;
   logic        measure_request__valid;
   logic        measure_response__valid;
   logic        measure_response__abort;
   logic        measure_response__initial_value;
   logic [8:0]  measure_response__delay;
   logic [8:0]  measure_response__initial_delay;
   logic        dprintf_req__valid;
   logic [15:0] dprintf_req__address;
   logic [63:0] dprintf_req__data_0;
   logic [63:0] dprintf_req__data_1;
   logic [63:0] dprintf_req__data_2;
   logic [63:0] dprintf_req__data_3;
   logic        dprintf_ack;

   modport master (
      output measure_request__valid,
      input  measure_response__valid,
      input  measure_response__abort,
      input  measure_response__initial_value,
      input  measure_response__delay,
      input  measure_response__initial_delay,
      output dprintf_req__valid,
      output dprintf_req__address,
      output dprintf_req__data_0,
      output dprintf_req__data_1,
      output dprintf_req__data_2,
      output dprintf_req__data_3,
      input  dprintf_ack
   );

   modport slave (
      input  measure_request__valid,
      output measure_response__valid,
      output measure_response__abort,
      output measure_response__initial_value,
      output measure_response__delay,
      output measure_response__initial_delay,
      input  dprintf_req__valid,
      input  dprintf_req__address,
      input  dprintf_req__data_0,
      input  dprintf_req__data_1,
      input  dprintf_req__data_2,
      input  dprintf_req__data_3,
      output dprintf_ack
   );
endinterface

// File: rtl/phase_measure_sequencer.sv
// Runs rounds of phase measurements, reduces each round to min/max/sum/abort/
// timeout statistics and reports the round as one dprintf request.
module phase_measure_sequencer #(
   parameter int unsigned NUM_SAMPLES     = 16,
   parameter int unsigned INTERVAL        = 1000000,
   parameter int unsigned TIMEOUT         = 4096,
   parameter logic [15:0] DPRINTF_ADDRESS = 16'd80
) (
   input  logic clk,
   input  logic reset,
   input  logic enable,
   output logic busy,
   phase_measure_sequencer_if.master bus
);
   localparam logic [15:0] NUM_SAMPLES_C = 16'(NUM_SAMPLES);
   localparam logic [31:0] INTERVAL_M1_C = 32'(INTERVAL - 32'd1);
   localparam logic [31:0] TIMEOUT_M1_C  = 32'(TIMEOUT - 32'd1);
   localparam logic [63:0] DATA_0_RST_C  = 64'h01FF_0000_0000_0000;

   typedef enum logic [1:0] {
      ST_GAP    = 2'd0,
      ST_REQ    = 2'd1,
      ST_SPACE  = 2'd2,
      ST_REPORT = 2'd3
   } state_t;

   state_t      state_r;
   logic [31:0] gap_count_r;
   logic [31:0] timer_r;
   logic [15:0] slot_count_r;
   logic [8:0]  min_r;
   logic [8:0]  max_r;
   logic [31:0] sum_r;
   logic [15:0] ok_count_r;
   logic [7:0]  abort_count_r;
   logic [7:0]  timeout_count_r;
   logic [8:0]  last_initial_delay_r;
   logic        last_initial_value_r;
   logic [23:0] round_number_r;
   logic        request_r;
   logic        report_valid_r;
   logic        busy_r;
   logic [63:0] data_0_r;
   logic [63:0] data_1_r;
   logic [63:0] data_2_r;

   function automatic logic [7:0] sat_inc8(input logic [7:0] value);
      sat_inc8 = (value == 8'hFF) ? value : value + 8'd1;
   endfunction

   assign bus.measure_request__valid = request_r;
   assign bus.dprintf_req__valid     = report_valid_r;
   assign bus.dprintf_req__address   = DPRINTF_ADDRESS;
   assign bus.dprintf_req__data_0    = data_0_r;
   assign bus.dprintf_req__data_1    = data_1_r;
   assign bus.dprintf_req__data_2    = data_2_r;
   assign bus.dprintf_req__data_3    = 64'd0;
   assign busy                       = busy_r;

   // Round sequencer: state, statistics and all registered outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r              <= ST_GAP;
         gap_count_r          <= 32'd0;
         timer_r              <= 32'd0;
         slot_count_r         <= 16'd0;
         min_r                <= 9'h1FF;
         max_r                <= 9'd0;
         sum_r                <= 32'd0;
         ok_count_r           <= 16'd0;
         abort_count_r        <= 8'd0;
         timeout_count_r      <= 8'd0;
         last_initial_delay_r <= 9'd0;
         last_initial_value_r <= 1'b0;
         round_number_r       <= 24'd0;
         request_r            <= 1'b0;
         report_valid_r       <= 1'b0;
         busy_r               <= 1'b0;
         data_0_r             <= DATA_0_RST_C;
         data_1_r             <= 64'd0;
         data_2_r             <= 64'd0;
      end else begin
         case (state_r)
            ST_GAP: begin
               if (gap_count_r != 32'd0) begin
                  gap_count_r <= gap_count_r - 32'd1;
               end else if (enable) begin
                  // Launch through one SPACE cycle so the first request
                  // rises one edge after enable is sampled.
                  slot_count_r         <= 16'd0;
                  timer_r              <= 32'd0;
                  min_r                <= 9'h1FF;
                  max_r                <= 9'd0;
                  sum_r                <= 32'd0;
                  ok_count_r           <= 16'd0;
                  abort_count_r        <= 8'd0;
                  timeout_count_r      <= 8'd0;
                  last_initial_delay_r <= 9'd0;
                  last_initial_value_r <= 1'b0;
                  busy_r               <= 1'b1;
                  state_r              <= ST_SPACE;
               end else begin
                  state_r <= ST_GAP;
               end
            end
            ST_REQ: begin
               if (bus.measure_response__valid) begin
                  if (bus.measure_response__abort) begin
                     abort_count_r <= sat_inc8(abort_count_r);
                  end else begin
                     ok_count_r <= ok_count_r + 16'd1;
                     sum_r      <= sum_r + {23'd0, bus.measure_response__delay};
                     if (bus.measure_response__delay < min_r) begin
                        min_r <= bus.measure_response__delay;
                     end
                     if (bus.measure_response__delay > max_r) begin
                        max_r <= bus.measure_response__delay;
                     end
                  end
                  last_initial_delay_r <= bus.measure_response__initial_delay;
                  last_initial_value_r <= bus.measure_response__initial_value;
                  slot_count_r         <= slot_count_r + 16'd1;
                  request_r            <= 1'b0;
                  state_r              <= ST_SPACE;
               end else if (timer_r == TIMEOUT_M1_C) begin
                  timeout_count_r <= sat_inc8(timeout_count_r);
                  slot_count_r    <= slot_count_r + 16'd1;
                  request_r       <= 1'b0;
                  state_r         <= ST_SPACE;
               end else begin
                  timer_r <= timer_r + 32'd1;
               end
            end
            ST_SPACE: begin
               timer_r <= 32'd0;
               if (slot_count_r == NUM_SAMPLES_C) begin
                  data_0_r       <= {7'h0, min_r, 7'h0, max_r, ok_count_r,
                                     abort_count_r, timeout_count_r};
                  data_1_r       <= {8'hFF, round_number_r, sum_r};
                  data_2_r       <= {46'h0, last_initial_value_r, 8'h0,
                                     last_initial_delay_r};
                  report_valid_r <= 1'b1;
                  state_r        <= ST_REPORT;
               end else begin
                  request_r <= 1'b1;
                  state_r   <= ST_REQ;
               end
            end
            ST_REPORT: begin
               if (bus.dprintf_ack) begin
                  report_valid_r <= 1'b0;
                  round_number_r <= round_number_r + 24'd1;
                  gap_count_r    <= INTERVAL_M1_C;
                  busy_r         <= 1'b0;
                  state_r        <= ST_GAP;
               end else begin
                  state_r <= ST_REPORT;
               end
            end
            default: begin
               request_r      <= 1'b0;
               report_valid_r <= 1'b0;
               busy_r         <= 1'b0;
               state_r        <= ST_GAP;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_phase_measure_sequencer.sv
// Randomized bench for phase_measure_sequencer: a responder/acker drives the
// bus and a round-level reference model predicts timing and report payloads.
module tb_phase_measure_sequencer;
   localparam int NS = 4;
   localparam int TO = 8;
   localparam int IV = 12;

   logic        clk = 1'b0;
   logic        reset;
   logic        enable;
   logic        busy;
   int          total;
   int          bad;
   int          edge_n;
   int          g_edge;
   int          en_edge;
   int          hold_cycles;
   int          en_extra;
   int          reset_slot;
   bit          was_reset;
   logic [23:0] round_no;
   int          pl_len    [NS];
   logic        pl_abort  [NS];
   logic [8:0]  pl_delay  [NS];
   logic [8:0]  pl_idelay [NS];
   logic        pl_ivalue [NS];

   phase_measure_sequencer_if bus ();

   phase_measure_sequencer #(
      .NUM_SAMPLES(NS), .INTERVAL(IV), .TIMEOUT(TO), .DPRINTF_ADDRESS(16'd80)
   ) dut (
      .clk(clk), .reset(reset), .enable(enable), .busy(busy), .bus(bus)
   );

   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog: run exceeded time limit");
      $fatal(1, "watchdog");
   end

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%h expected=%h (edge %0d)", tag, got, exp, edge_n);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      edge_n++;
   endtask

   // Random stray traffic; only used while the DUT is not requesting.
   task automatic drive_noise();
      bus.measure_response__valid         = ($urandom_range(0, 3) == 0);
      bus.measure_response__abort         = 1'($urandom_range(0, 1));
      bus.measure_response__initial_value = 1'($urandom_range(0, 1));
      bus.measure_response__delay         = 9'($urandom_range(0, 511));
      bus.measure_response__initial_delay = 9'($urandom_range(0, 511));
      bus.dprintf_ack = (bus.dprintf_req__valid == 1'b0) ? 1'($urandom_range(0, 1)) : 1'b0;
   endtask

   task automatic set_plan(input int s, input int len, input logic ab, input int dly,
                           input int idly, input logic iv);
      pl_len[s]    = len;
      pl_abort[s]  = ab;
      pl_delay[s]  = 9'(dly);
      pl_idelay[s] = 9'(idly);
      pl_ivalue[s] = iv;
   endtask

   task automatic plan_random();
      int r;
      for (int s = 0; s < NS; s++) begin
         r = $urandom_range(0, 9);
         set_plan(s, (r < 2) ? TO + 1 : (r == 2) ? TO : $urandom_range(1, TO - 1),
                  1'($urandom_range(0, 3) == 0), $urandom_range(0, 511),
                  $urandom_range(0, 511), 1'($urandom_range(0, 1)));
      end
   endtask

   task automatic wait_request();
      int exp_edge;
      int n;
      exp_edge = ((g_edge + 1 > en_edge) ? g_edge + 1 : en_edge) + 1;
      n = 0;
      while (bus.measure_request__valid !== 1'b1 && n < 500) begin
         drive_noise();
         enable = (edge_n + 1 >= en_edge);
         step();
         n++;
         if (edge_n < exp_edge - 1) check_eq("busy_in_gap", busy, 1'b0);
      end
      check_eq("req_rise_edge", edge_n, exp_edge);
      check_eq("busy_in_req", busy, 1'b1);
   endtask

   task automatic run_round(output bit rst_hit);
      int          start_edge;
      int          c;
      bit          all_fast;
      logic [8:0]  mn, mx, li;
      logic        lv;
      logic [31:0] sum;
      logic [15:0] ok;
      logic [7:0]  ab, tmo;
      logic [63:0] e0, e1, e2;
      rst_hit = 1'b0;
      wait_request();
      start_edge = edge_n;
      all_fast = 1'b1;
      for (int s = 0; s < NS; s++) begin
         if (s == reset_slot) begin
            reset = 1'b1;
            bus.measure_response__valid = 1'b0;
            step();
            check_eq("reset_req", bus.measure_request__valid, 1'b0);
            check_eq("reset_valid", bus.dprintf_req__valid, 1'b0);
            check_eq("reset_busy", busy, 1'b0);
            check_eq("reset_d0", bus.dprintf_req__data_0, 64'h01FF_0000_0000_0000);
            check_eq("reset_d1", bus.dprintf_req__data_1, 64'd0);
            reset = 1'b0;
            g_edge = edge_n;
            en_edge = edge_n + 1;
            round_no = 24'd0;
            reset_slot = -1;
            rst_hit = 1'b1;
            return;
         end
         for (c = 1; c <= TO + 2; c++) begin
            enable = 1'($urandom_range(0, 1));
            bus.dprintf_ack = (bus.dprintf_req__valid == 1'b0) ? 1'($urandom_range(0, 1)) : 1'b0;
            bus.measure_response__valid         = (c == pl_len[s]);
            bus.measure_response__abort         = pl_abort[s];
            bus.measure_response__delay         = pl_delay[s];
            bus.measure_response__initial_delay = pl_idelay[s];
            bus.measure_response__initial_value = pl_ivalue[s];
            step();
            if (bus.measure_request__valid !== 1'b1) break;
         end
         check_eq("req_high_len", c, (pl_len[s] <= TO) ? pl_len[s] : TO);
         if (pl_len[s] != 2) all_fast = 1'b0;
         drive_noise();
         enable = 1'($urandom_range(0, 1));
         step();
         if (s < NS - 1) check_eq("space_then_req", bus.measure_request__valid, 1'b1);
         else check_eq("space_then_report", bus.dprintf_req__valid, 1'b1);
      end
      // Reference statistics for the round, straight from the slot plan.
      mn = 9'h1FF; mx = 9'd0; sum = 32'd0; ok = 16'd0; ab = 8'd0; tmo = 8'd0;
      li = 9'd0; lv = 1'b0;
      for (int s = 0; s < NS; s++) begin
         if (pl_len[s] > TO) begin
            if (tmo != 8'hFF) tmo = tmo + 8'd1;
         end else begin
            li = pl_idelay[s];
            lv = pl_ivalue[s];
            if (pl_abort[s]) begin
               if (ab != 8'hFF) ab = ab + 8'd1;
            end else begin
               ok  = ok + 16'd1;
               sum = sum + 32'(pl_delay[s]);
               if (pl_delay[s] < mn) mn = pl_delay[s];
               if (pl_delay[s] > mx) mx = pl_delay[s];
            end
         end
      end
      e0 = {7'h0, mn, 7'h0, mx, ok, ab, tmo};
      e1 = {8'hFF, round_no, sum};
      e2 = {46'h0, lv, 8'h0, li};
      if (all_fast) check_eq("round_cycles", edge_n - start_edge, 3 * NS);
      check_eq("rpt_busy", busy, 1'b1);
      check_eq("rpt_no_req", bus.measure_request__valid, 1'b0);
      for (int h = 0; h <= hold_cycles; h++) begin
         check_eq("rpt_valid", bus.dprintf_req__valid, 1'b1);
         check_eq("rpt_d0", bus.dprintf_req__data_0, e0);
         check_eq("rpt_d1", bus.dprintf_req__data_1, e1);
         check_eq("rpt_d2", bus.dprintf_req__data_2, e2);
         check_eq("rpt_d3", bus.dprintf_req__data_3, 64'd0);
         check_eq("rpt_addr", bus.dprintf_req__address, 64'd80);
         drive_noise();
         bus.dprintf_ack = (h == hold_cycles);
         enable = 1'($urandom_range(0, 1));
         step();
      end
      bus.dprintf_ack = 1'b0;
      check_eq("valid_after_ack", bus.dprintf_req__valid, 1'b0);
      check_eq("busy_after_ack", busy, 1'b0);
      round_no = round_no + 24'd1;
      g_edge = edge_n + IV - 1;
      en_edge = edge_n + IV - 3 + en_extra;
   endtask

   initial begin
      total = 0; bad = 0; edge_n = 0; round_no = 24'd0;
      reset = 1'b1; enable = 1'b0; reset_slot = -1; hold_cycles = 0; en_extra = 0;
      bus.measure_response__valid = 1'b0;
      bus.measure_response__abort = 1'b0;
      bus.measure_response__initial_value = 1'b0;
      bus.measure_response__delay = 9'd0;
      bus.measure_response__initial_delay = 9'd0;
      bus.dprintf_ack = 1'b0;
      repeat (3) step();
      check_eq("rst_req", bus.measure_request__valid, 1'b0);
      check_eq("rst_valid", bus.dprintf_req__valid, 1'b0);
      check_eq("rst_busy", busy, 1'b0);
      check_eq("rst_d0", bus.dprintf_req__data_0, 64'h01FF_0000_0000_0000);
      check_eq("rst_d1", bus.dprintf_req__data_1, 64'd0);
      check_eq("rst_d2", bus.dprintf_req__data_2, 64'd0);
      check_eq("rst_d3", bus.dprintf_req__data_3, 64'd0);
      reset = 1'b0;
      g_edge = edge_n;
      en_edge = edge_n + 1;

      // Four fast responses: min 7, max 300, sum 0x16A.
      set_plan(0, 2, 1'b0, 10, 33, 1'b1);
      set_plan(1, 2, 1'b0, 300, 44, 1'b0);
      set_plan(2, 2, 1'b0, 7, 55, 1'b1);
      set_plan(3, 2, 1'b0, 45, 66, 1'b1);
      hold_cycles = 2;
      en_extra = 103;
      run_round(was_reset);

      // Abort with large delay, response exactly at the timeout boundary, one timeout.
      set_plan(0, 2, 1'b0, 20, 1, 1'b0);
      set_plan(1, 3, 1'b1, 500, 2, 1'b1);
      set_plan(2, TO, 1'b0, 30, 3, 1'b0);
      set_plan(3, TO + 1, 1'b0, 0, 4, 1'b1);
      hold_cycles = 0;
      en_extra = 0;
      run_round(was_reset);

      // Silent responder, long ack stall.
      for (int s = 0; s < NS; s++) set_plan(s, TO + 1, 1'b0, 0, 0, 1'b0);
      hold_cycles = 50;
      run_round(was_reset);

      plan_random();
      reset_slot = 2;
      run_round(was_reset);
      check_eq("reset_hit", was_reset, 1'b1);

      for (int r = 0; r < 16; r++) begin
         plan_random();
         hold_cycles = $urandom_range(0, 4);
         en_extra = $urandom_range(0, 6);
         run_round(was_reset);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
